// File: rtl/id_decode_queue_if.sv
// Fetch/execute-facing bundle of the RV32I decode queue.
//  slave  : seen by id_decode_queue (accepts fetch, presents decoded head)
//  master : seen by whoever drives fetch and consumes the head
//  flush, in_valid, in_inst, in_pc, out_ready  : towards the queue
//  in_ready, out_valid, out_inst, out_pc, out_ctrl, out_count : from the queue
// Optional feature macro: RV32M_EN widens out_ctrl from 26 to 30 bits.
interface id_decode_queue_if #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned BUF_DEPTH = 2
);
`ifdef RV32M_EN
    localparam int unsigned CTRL_W = 30;
`else
    localparam int unsigned CTRL_W = 26;
`endif
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [PC_W-1:0]   out_pc;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  out_count;

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_ctrl, out_count
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_ctrl, out_count
    );
endinterface

// File: rtl/id_decode_queue.sv
// Registered RV32I decode stage: decodes each accepted instruction into a packed
// control word and holds {inst, pc, ctrl} in a BUF_DEPTH-entry in-order queue.
// Ports:
//  clk   : rising-edge clock
//  rstn  : asynchronous active-low reset
//  q     : id_decode_queue_if.slave (fetch valid/ready, execute valid/ready, flush, count)
// Optional feature macro: RV32M_EN (decode RV32M, out_ctrl[29:26] = {md_en, md_op}).
// out_ctrl[25:0] = {illegal, store_type, load_type, rf_we, rf_wd_sel, rf_re1, rf_re0,
//                   imm_type, mem_we, alu_func, alu_src2_sel, alu_src1_sel, br_type, jalr, jal}
module id_decode_queue #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rstn,
    id_decode_queue_if.slave q
);
`ifdef RV32M_EN
    localparam int unsigned CTRL_W = 30;
`else
    localparam int unsigned CTRL_W = 26;
`endif
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU function for the shared OP/OP-IMM funct3 space (base encoding, funct7=0)
    function automatic logic [3:0] alu_of_f3(input logic [2:0] f3);
        logic [3:0] a;
        case (f3)
            3'b000:  a = 4'd0;   // add
            3'b001:  a = 4'd9;   // sll
            3'b010:  a = 4'd4;   // slt
            3'b011:  a = 4'd3;   // sltu
            3'b100:  a = 4'd7;   // xor
            3'b101:  a = 4'd8;   // srl
            3'b110:  a = 4'd6;   // or
            default: a = 4'd5;   // and
        endcase
        return a;
    endfunction

    // Full instruction decode; illegal encodings collapse to a lone illegal bit
    function automatic logic [CTRL_W-1:0] decode(input logic [31:0] inst);
        logic [6:0]        opc;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic              illegal;
        logic [1:0]        store_type;
        logic [2:0]        load_type;
        logic              writes_rd;
        logic              reads_rs1;
        logic              reads_rs2;
        logic [1:0]        rf_wd_sel;
        logic [2:0]        imm_type;
        logic              mem_we;
        logic [3:0]        alu_func;
        logic              src2_imm;
        logic              src1_pc;
        logic [2:0]        br_type;
        logic              jalr;
        logic              jal;
`ifdef RV32M_EN
        logic              md_en;
        logic [2:0]        md_op;
`endif
        logic [CTRL_W-1:0] ctrl;

        opc        = inst[6:0];
        f3         = inst[14:12];
        f7         = inst[31:25];
        illegal    = 1'b0;
        store_type = 2'd0;
        load_type  = 3'd0;
        writes_rd  = 1'b0;
        reads_rs1  = 1'b0;
        reads_rs2  = 1'b0;
        rf_wd_sel  = 2'd0;
        imm_type   = 3'd0;
        mem_we     = 1'b0;
        alu_func   = 4'd0;
        src2_imm   = 1'b1;
        src1_pc    = 1'b0;
        br_type    = 3'd0;
        jalr       = 1'b0;
        jal        = 1'b0;
`ifdef RV32M_EN
        md_en      = 1'b0;
        md_op      = 3'd0;
`endif

        case (opc)
            OPC_LUI: begin
                imm_type  = 3'd4;
                rf_wd_sel = 2'd3;
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                imm_type  = 3'd4;
                src1_pc   = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                imm_type  = 3'd5;
                src1_pc   = 1'b1;
                jal       = 1'b1;
                rf_wd_sel = 2'd1;
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                illegal   = (f3 != 3'b000);
                imm_type  = 3'd1;
                jalr      = 1'b1;
                rf_wd_sel = 2'd1;
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                imm_type  = 3'd3;
                src1_pc   = 1'b1;
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
                case (f3)
                    3'b000:  br_type = 3'd1;
                    3'b001:  br_type = 3'd2;
                    3'b100:  br_type = 3'd3;
                    3'b101:  br_type = 3'd4;
                    3'b110:  br_type = 3'd5;
                    3'b111:  br_type = 3'd6;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                imm_type  = 3'd1;
                rf_wd_sel = 2'd2;
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
                case (f3)
                    3'b000:  load_type = 3'd1;
                    3'b001:  load_type = 3'd2;
                    3'b010:  load_type = 3'd3;
                    3'b100:  load_type = 3'd4;
                    3'b101:  load_type = 3'd5;
                    default: illegal   = 1'b1;
                endcase
            end
            OPC_STORE: begin
                imm_type  = 3'd2;
                mem_we    = 1'b1;
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
                case (f3)
                    3'b000:  store_type = 2'd1;
                    3'b001:  store_type = 2'd2;
                    3'b010:  store_type = 2'd3;
                    default: illegal    = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                imm_type  = 3'd1;
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
                alu_func  = alu_of_f3(f3);
                // shift-immediates carry funct7 in imm[11:5]
                if (f3 == 3'b001) begin
                    illegal = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'b0100000) begin
                        alu_func = 4'd10;
                    end else if (f7 != 7'b0000000) begin
                        illegal = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                src2_imm  = 1'b0;
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
                if (f7 == 7'b0000000) begin
                    alu_func = alu_of_f3(f3);
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'b000) begin
                        alu_func = 4'd1;
                    end else if (f3 == 3'b101) begin
                        alu_func = 4'd10;
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (f7 == 7'b0000001) begin
`ifdef RV32M_EN
                    md_en = 1'b1;
                    md_op = f3;
`else
                    illegal = 1'b1;
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        ctrl = '0;
        if (illegal) begin
            ctrl[25] = 1'b1;
        end else begin
            ctrl[25:0] = {1'b0, store_type, load_type,
                          writes_rd & (|inst[11:7]), rf_wd_sel,
                          reads_rs2 & (|inst[24:20]), reads_rs1 & (|inst[19:15]),
                          imm_type, mem_we, alu_func, src2_imm, src1_pc,
                          br_type, jalr, jal};
`ifdef RV32M_EN
            ctrl[29:26] = {md_en, md_op};
`endif
        end
        return ctrl;
    endfunction

    logic [31:0]       inst_mem [BUF_DEPTH];
    logic [PC_W-1:0]   pc_mem   [BUF_DEPTH];
    logic [CTRL_W-1:0] ctrl_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push_c;
    logic              pop_c;
    logic              not_empty_c;

    // rstn gates in_ready so nothing is accepted while reset is held
    assign q.in_ready  = rstn && (count < CNT_W'(BUF_DEPTH)) && !q.flush;
    assign not_empty_c = (count != '0);
    assign push_c      = q.in_valid && q.in_ready;
    assign pop_c       = not_empty_c && q.out_ready && !q.flush;

    // Pointers and occupancy; flush discards everything including this cycle's traffic
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count <= count + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage; decode happens on the way in so the head is already registered
    always_ff @(posedge clk) begin
        if (push_c) begin
            inst_mem[wr_ptr] <= q.in_inst;
            pc_mem[wr_ptr]   <= q.in_pc;
            ctrl_mem[wr_ptr] <= decode(q.in_inst);
        end
    end

    // Head presentation; empty queue shows a NOP with zero pc/ctrl
    assign q.out_valid = not_empty_c;
    assign q.out_count = count;
    assign q.out_inst  = not_empty_c ? inst_mem[rd_ptr] : NOP;
    assign q.out_pc    = not_empty_c ? pc_mem[rd_ptr]   : '0;
    assign q.out_ctrl  = not_empty_c ? ctrl_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_id_decode_queue.sv
// Bench for id_decode_queue: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_id_decode_queue;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [29:0] ctrl;
    } ent_t;

    logic clk;
    logic rstn;
    bit   cmp_en;
    int   n_chk;
    int   n_pass;
    ent_t mq[$];

    id_decode_queue_if #(.PC_W(PC_W), .BUF_DEPTH(DEPTH)) q ();
    id_decode_queue #(.PC_W(PC_W), .BUF_DEPTH(DEPTH)) dut (.clk(clk), .rstn(rstn), .q(q));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode from the ISA tables: classify, fill named fields, place by bit position
    function automatic logic [29:0] ref_decode(input logic [31:0] i);
        int    opc, f3, f7, rd, rs1, rs2;
        int    alu_tab[8];
        int    br_tab[8];
        int    ld_tab[8];
        int    st_tab[8];
        bit    bad, writes, r1, r2, s1pc, memw, jl, jr, md;
        int    alu, imm, br, ld, st, wd, mdop;
        logic [29:0] c;
        alu_tab = '{0, 9, 4, 3, 7, 8, 6, 5};
        br_tab  = '{1, 2, 0, 0, 3, 4, 5, 6};
        ld_tab  = '{1, 2, 3, 0, 4, 5, 0, 0};
        st_tab  = '{1, 2, 3, 0, 0, 0, 0, 0};
        opc = int'(i[6:0]);  f3 = int'(i[14:12]); f7 = int'(i[31:25]);
        rd  = int'(i[11:7]); rs1 = int'(i[19:15]); rs2 = int'(i[24:20]);
        bad = 0; writes = 0; r1 = 0; r2 = 0; s1pc = 0; memw = 0; jl = 0; jr = 0; md = 0;
        alu = 0; imm = 0; br = 0; ld = 0; st = 0; wd = 0; mdop = 0;
        if (opc == 'h37) begin imm = 4; wd = 3; writes = 1; end
        else if (opc == 'h17) begin imm = 4; s1pc = 1; writes = 1; end
        else if (opc == 'h6F) begin imm = 5; s1pc = 1; jl = 1; wd = 1; writes = 1; end
        else if (opc == 'h67) begin imm = 1; jr = 1; wd = 1; writes = 1; r1 = 1; bad = (f3 != 0); end
        else if (opc == 'h63) begin imm = 3; s1pc = 1; r1 = 1; r2 = 1; br = br_tab[f3]; bad = (br == 0); end
        else if (opc == 'h03) begin imm = 1; wd = 2; writes = 1; r1 = 1; ld = ld_tab[f3]; bad = (ld == 0); end
        else if (opc == 'h23) begin imm = 2; memw = 1; r1 = 1; r2 = 1; st = st_tab[f3]; bad = (st == 0); end
        else if (opc == 'h13) begin
            imm = 1; writes = 1; r1 = 1; alu = alu_tab[f3];
            if (f3 == 1 && f7 != 0) bad = 1;
            if (f3 == 5 && f7 == 'h20) alu = 10;
            else if (f3 == 5 && f7 != 0) bad = 1;
        end else if (opc == 'h33) begin
            writes = 1; r1 = 1; r2 = 1;
            if (f7 == 0) alu = alu_tab[f3];
            else if (f7 == 'h20 && f3 == 0) alu = 1;
            else if (f7 == 'h20 && f3 == 5) alu = 10;
`ifdef RV32M_EN
            else if (f7 == 1) begin md = 1; mdop = f3; end
`endif
            else bad = 1;
        end else bad = 1;
        if (bad) return 30'h200_0000;
        c = '0;
        c = c | 30'(jl) | (30'(jr) << 1) | (30'(br) << 2) | (30'(s1pc) << 5);
        c = c | (30'(opc != 'h33) << 6) | (30'(alu) << 7) | (30'(memw) << 11) | (30'(imm) << 12);
        c = c | (30'(r1 && rs1 != 0) << 15) | (30'(r2 && rs2 != 0) << 16) | (30'(wd) << 17);
        c = c | (30'(writes && rd != 0) << 19) | (30'(ld) << 20) | (30'(st) << 23);
        c = c | (30'(md) << 29) | (30'(mdop) << 26);
        return c;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_step();
        bit   push, pop;
        ent_t e;
        if (!rstn || q.flush) begin
            mq.delete();
            return;
        end
        push = q.in_valid && (mq.size() < DEPTH);
        pop  = (mq.size() != 0) && q.out_ready;
        if (pop) void'(mq.pop_front());
        if (push) begin
            e.inst = q.in_inst;
            e.pc   = q.in_pc;
            e.ctrl = ref_decode(q.in_inst);
            mq.push_back(e);
        end
    endtask

    task automatic cyc(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit rdy, input bit fl);
        q.in_valid  = v;
        q.in_inst   = inst;
        q.in_pc     = pc;
        q.out_ready = rdy;
        q.flush     = fl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 10))
            0: r[6:0] = 7'h37;  1: r[6:0] = 7'h17;  2: r[6:0] = 7'h6F;
            3: r[6:0] = 7'h67;  4: r[6:0] = 7'h63;  5: r[6:0] = 7'h03;
            6: r[6:0] = 7'h23;  7, 8: r[6:0] = 7'h13;  9: r[6:0] = 7'h33;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        return r;
    endfunction

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", 64'(q.in_ready), 64'(rstn && mq.size() < DEPTH && !q.flush));
            chk("out_valid", 64'(q.out_valid), 64'(mq.size() != 0));
            chk("out_count", 64'(q.out_count), 64'(mq.size()));
            if (mq.size() != 0) begin
                chk("out_inst", 64'(q.out_inst), 64'(mq[0].inst));
                chk("out_pc", 64'(q.out_pc), 64'(mq[0].pc));
                chk("out_ctrl", 64'(q.out_ctrl), 64'(mq[0].ctrl));
            end else begin
                chk("idle_inst", 64'(q.out_inst), 64'h13);
                chk("idle_pc", 64'(q.out_pc), 64'h0);
                chk("idle_ctrl", 64'(q.out_ctrl), 64'h0);
            end
        end
    end

    initial begin
        n_chk = 0; n_pass = 0; cmp_en = 1'b0;
        q.in_valid = 1'b0; q.in_inst = '0; q.in_pc = '0; q.out_ready = 1'b0; q.flush = 1'b0;
        rstn = 1'b1;
        #1 rstn = 1'b0;

        // model pins
        chk("model_addi", 64'(ref_decode(32'h00500093)), 64'h81040);
        chk("model_beq", 64'(ref_decode(32'h00208063)), 64'h1B064);
        chk("model_bad_br", 64'(ref_decode(32'h0000A063)), 64'h200_0000);

        // reset state
        #2;
        chk("rst_in_ready", 64'(q.in_ready), 64'h0);
        chk("rst_out_inst", 64'(q.out_inst), 64'h13);
        chk("rst_count", 64'(q.out_count), 64'h0);
        @(negedge clk); #1;
        rstn = 1'b1;
        #1;
        chk("rel_in_ready", 64'(q.in_ready), 64'h1);
        cmp_en = 1'b1;

        // addi x1,x0,5 through an empty queue
        cyc(1, 32'h00500093, 32'h100, 1, 0);
        chk("addi_valid", 64'(q.out_valid), 64'h1);
        chk("addi_ctrl", 64'(q.out_ctrl), 64'h81040);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("addi_popped", 64'(q.out_count), 64'h0);

        // backpressure: third push held while full, order kept
        cyc(1, 32'h00100113, 32'h200, 0, 0);
        cyc(1, 32'h00200193, 32'h204, 0, 0);
        chk("full_in_ready", 64'(q.in_ready), 64'h0);
        cyc(1, 32'h00300213, 32'h208, 0, 0);
        chk("full_count", 64'(q.out_count), 64'h2);
        chk("full_head", 64'(q.out_inst), 64'h00100113);
        cyc(1, 32'h00300213, 32'h208, 1, 0);
        chk("drain_head1", 64'(q.out_inst), 64'h00200193);
        cyc(1, 32'h00300213, 32'h208, 1, 0);
        chk("drain_head2", 64'(q.out_inst), 64'h00300213);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("drain_empty", 64'(q.out_valid), 64'h0);

        // flush with a concurrent push
        cyc(1, 32'h00100113, 32'h300, 0, 0);
        cyc(1, 32'h00200193, 32'h304, 0, 0);
        cyc(1, 32'h00300213, 32'h308, 1, 1);
        chk("flush_count", 64'(q.out_count), 64'h0);
        chk("flush_valid", 64'(q.out_valid), 64'h0);
        cyc(0, 32'h0, 32'h0, 0, 0);

        // illegal encodings still queue in order
        cyc(1, 32'h0000A063, 32'h400, 0, 0);
        cyc(1, 32'hFFFFFFFF, 32'h404, 0, 0);
        chk("ill_head", 64'(q.out_inst), 64'h0000A063);
        chk("ill_ctrl1", 64'(q.out_ctrl), 64'h200_0000);
        cyc(0, 32'h0, 32'h0, 1, 0);
        chk("ill_head2", 64'(q.out_inst), 64'hFFFFFFFF);
        chk("ill_ctrl2", 64'(q.out_ctrl), 64'h200_0000);
        cyc(0, 32'h0, 32'h0, 1, 0);

        // mul x0,x1,x2
        cyc(1, 32'h02208033, 32'h500, 0, 0);
`ifdef RV32M_EN
        chk("mul_ctrl", 64'(q.out_ctrl), 64'h2001_8000);
`else
        chk("mul_ctrl", 64'(q.out_ctrl), 64'h200_0000);
`endif
        cyc(0, 32'h0, 32'h0, 1, 0);

        // asynchronous reset with two entries queued
        cyc(1, 32'h00100113, 32'h600, 0, 0);
        cyc(1, 32'h00200193, 32'h604, 0, 0);
        rstn = 1'b0;
        mq.delete();
        #1;
        chk("arst_valid", 64'(q.out_valid), 64'h0);
        chk("arst_in_ready", 64'(q.in_ready), 64'h0);
        chk("arst_inst", 64'(q.out_inst), 64'h13);
        chk("arst_pc", 64'(q.out_pc), 64'h0);
        cyc(1, 32'h00300213, 32'h608, 1, 0);
        cyc(1, 32'h00300213, 32'h608, 1, 0);
        rstn = 1'b1;
        #1;
        chk("arst_rel_ready", 64'(q.in_ready), 64'h1);
        cyc(1, 32'h00500093, 32'h700, 0, 0);
        chk("arst_restart", 64'(q.out_ctrl), 64'h81040);
        cyc(0, 32'h0, 32'h0, 1, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 9) < 7), rand_inst(), $urandom,
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
